// File: rtl/seq_chunk_adder_pkg.sv
// rtl/seq_chunk_adder_pkg.sv - shared state encoding and default sizes for the chunked adder
package adder_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - request/response bundle between a requester and the chunked adder
interface seq_chunk_adder_if #(parameter int WIDTH = adder_pkg::DEF_WIDTH);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (output start, mode, a, b, ci,
                    input  busy, done, result, cout, ovf);
    modport slave  (input  start, mode, a, b, ci,
                    output busy, done, result, cout, ovf);
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// rtl/seq_chunk_adder_chunk.sv - combinational CHUNK-bit adder exposing carry into and out of its MSB
module chunk_adder #(
    parameter int CHUNK = adder_pkg::DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             co_msb_in
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    // The MSB sum bit is a^b^cin, so the carry into it falls out of the sum.
    assign co_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract, one CHUNK-bit slice per clock, LS chunk first
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_chunk_adder_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_size
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               c_r;
    logic [WIDTH-1:0]   result_r;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   s_chunk;
    logic               co_chunk;
    logic               co_msb_in;

    assign a_chunk = a_r[cnt*CHUNK +: CHUNK];
    assign b_chunk = b_r[cnt*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a         (a_chunk),
        .b         (b_chunk),
        .ci        (c_r),
        .s         (s_chunk),
        .co        (co_chunk),
        .co_msb_in (co_msb_in)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= 1'b0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        // Subtract is A + ~B + 1; ci only matters for add.
                        a_r    <= bus.a;
                        b_r    <= bus.mode ? ~bus.b : bus.b;
                        c_r    <= bus.mode ? 1'b1 : bus.ci;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    result_r[cnt*CHUNK +: CHUNK] <= s_chunk;
                    c_r <= co_chunk;
                    if (cnt == CNT_W'(N - 1)) begin
                        cout_r <= co_chunk;
                        ovf_r  <= co_chunk ^ co_msb_in;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - table-driven scoreboard bench for seq_chunk_adder
module tb_seq_chunk_adder;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) bus  ();
    seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] exp_r;
        logic        exp_c;
        logic        exp_o;
    } vec_t;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic sb_compare(string tag);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s sb_empty: got done with no pending entry, expected none", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s result", tag), 32'(bus.result), 32'(e.r));
            check($sformatf("%s cout", tag),   32'(bus.cout),   32'(e.c));
            check($sformatf("%s ovf", tag),    32'(bus.ovf),    32'(e.o));
        end
    endtask

    task automatic drive(input vec_t v);
        bus.start = 1'b1;
        bus.mode  = v.mode;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.ci    = v.ci;
    endtask

    task automatic do_op(input vec_t v, input bit pulse_mid, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_k   = -1;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        sb.push_back('{r: v.exp_r, c: v.exp_c, o: v.exp_o});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (pulse_mid && k == 2) begin
                bus.start = 1'b1;
                bus.mode  = ~v.mode;
                bus.a     = 16'hA5A5;
                bus.b     = 16'h1357;
                bus.ci    = 1'b1;
            end
            if (k == 3) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                sb_compare(tag);
            end
        end
        check($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
        check($sformatf("%s done_latency", tag), 32'(done_k), 32'd5);
        check($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'd5);
        check($sformatf("%s hold_result", tag), 32'(bus.result), 32'(v.exp_r));
    endtask

    initial begin
        int dcount;
        int d1;
        int d2;

        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0;  bus.mode = 1'b0;  bus.a = '0;  bus.b = '0;  bus.ci = 1'b0;
        bus8.start = 1'b0; bus8.mode = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy",   32'(bus.busy),   32'd0);
        check("reset done",   32'(bus.done),   32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset cout",   32'(bus.cout),   32'd0);
        check("reset ovf",    32'(bus.ovf),    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        do_op(vecs[3], 1'b1, "ignore_start_in_calc");

        // Reset two cycles into CALC must abort without a done pulse.
        @(negedge clk);
        drive(vecs[3]);
        @(posedge clk);
        dcount = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 3) rst_n = 1'b0;
            if (k == 4) begin
                rst_n = 1'b1;
                check("abort busy",   32'(bus.busy),   32'd0);
                check("abort done",   32'(bus.done),   32'd0);
                check("abort result", 32'(bus.result), 32'd0);
                check("abort cout",   32'(bus.cout),   32'd0);
            end
            if (bus.done) dcount++;
        end
        check("abort no_done", 32'(dcount), 32'd0);
        do_op(vecs[1], 1'b0, "after_abort");

        // Start held high: start during DONE is ignored, next accept on the following IDLE.
        @(negedge clk);
        drive(vecs[5]);
        @(posedge clk);
        sb.push_back('{r: vecs[5].exp_r, c: vecs[5].exp_c, o: vecs[5].exp_o});
        sb.push_back('{r: vecs[5].exp_r, c: vecs[5].exp_c, o: vecs[5].exp_o});
        dcount = 0; d1 = -1; d2 = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) bus.start = 1'b0;
            if (bus.done) begin
                dcount++;
                if (dcount == 1) d1 = k;
                if (dcount == 2) d2 = k;
                sb_compare("held_start");
            end
        end
        check("held_start done_count", 32'(dcount), 32'd2);
        check("held_start first_done", 32'(d1), 32'd5);
        check("held_start second_done", 32'(d2), 32'd11);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Single-chunk configuration.
        @(negedge clk);
        bus8.start = 1'b1; bus8.mode = 1'b0; bus8.a = 8'h80; bus8.b = 8'h80; bus8.ci = 1'b0;
        @(posedge clk);
        dcount = 0; d1 = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start = 1'b0;
            if (bus8.done) begin
                dcount++;
                if (d1 < 0) d1 = k;
                check("w8 result", 32'(bus8.result), 32'h00);
                check("w8 cout",   32'(bus8.cout),   32'd1);
                check("w8 ovf",    32'(bus8.ovf),    32'd1);
            end
        end
        check("w8 done_count", 32'(dcount), 32'd1);
        check("w8 done_latency", 32'(d1), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and an illegal pair SHALL fail elaboration.
REQ-003 Port clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port rst_n  input  1  reset: synchronous and active-low.
REQ-005 Port start  input  1  request to begin one operation.
REQ-006 Port mode  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 Port a  input  WIDTH  first operand.
REQ-008 Port b  input  WIDTH  second operand.
REQ-009 Port ci  input  1  carry in; used only when mode = 0.
REQ-010 Port busy  output  1  high while an operation is in progress.
REQ-011 Port done  output  1  one-cycle pulse marking the result as valid.
REQ-012 Port result  output  WIDTH  sum or difference.
REQ-013 Port cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
REQ-014 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have exactly three states:
- IDLE -> CALC when start is sampled high.
- CALC -> DONE after N = WIDTH/CHUNK chunk cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 On the edge where start is accepted, the block SHALL capture a, b, mode and an effective carry, then ignore these inputs until the next IDLE.
- Add: operand B = b, effective carry = ci.
- Subtract: operand B = ~b, effective carry = 1.
REQ-017 Each CALC cycle i (i = 0..N-1) SHALL add chunk i of the captured A and B plus the registered carry, least significant chunk first.
- The CHUNK-bit sum SHALL be stored into result bits [i*CHUNK +: CHUNK].
- The chunk carry-out SHALL become the registered carry for chunk i+1.
REQ-018 done SHALL be high for exactly one cycle, N+1 cycles after the start-accept edge.
- busy SHALL be high from the cycle after the accept edge through the done cycle, inclusive.
REQ-019 While done is high, result, cout and ovf SHALL equal:
- Add: A + B + ci, truncated to WIDTH bits.
- ovf = carry into MSB XOR carry out of MSB.
REQ-020 result, cout and ovf SHALL hold their values after done until the next start is accepted.
- During CALC they may show partial values, and the bench SHALL NOT check them then.
REQ-021 start SHALL be ignored while busy is high, including the DONE cycle; no queuing.
REQ-022 start held high continuously SHALL start a new operation on the first IDLE cycle after DONE, giving back-to-back periods of N+2 cycles.
REQ-023 CHUNK = WIDTH (N = 1) SHALL be legal: one CALC cycle, done two cycles after the accept edge.

Reset
REQ-024 When rst_n is sampled low on a rising edge:
- State SHALL go to IDLE.
- busy, done, cout, ovf SHALL be 0 and result SHALL be all zeros.
- Captured operands and the carry register SHALL be cleared.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse.
- The first start sampled after rst_n returns high SHALL be accepted normally.
REQ-026 The reset cycle SHALL have priority over a concurrent start.

Structure
REQ-027 The state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2) and the default WIDTH/CHUNK values SHALL live in the shared package adder_pkg.
REQ-028 The per-cycle arithmetic SHALL be a single instance of the combinational sub-module chunk_adder.
- chunk_adder is parametrised by CHUNK.
- Ports: a, b, ci in; s, co out; co_msb_in out, the carry into its MSB, used for ovf.
REQ-029 Chunk selection SHALL use a log2(N)-bit chunk counter; the RTL SHALL NOT build a full WIDTH-bit combinational adder.

Verification
All scenarios use WIDTH=16, CHUNK=4 unless noted.
REQ-030 Bench SHALL cover: add, a=16'hFFFF, b=16'h0001, ci=0 -> result 16'h0000, cout=1, ovf=0; done exactly 5 cycles after the accept edge; busy high for 5 cycles.
REQ-031 Bench SHALL cover: add, a=16'h7FFF, b=16'h0000, ci=1 -> result 16'h8000, cout=0, ovf=1.
REQ-032 Bench SHALL cover: subtract, a=16'h0005, b=16'h0007, ci=1 (ignored) -> result 16'hFFFE, cout=0, ovf=0.
REQ-033 Bench SHALL cover: pulse start again during CALC with different operands -> ignored; the first operation's result is unchanged and exactly one done is seen.
REQ-034 Bench SHALL cover: rst_n=0 for one cycle two cycles into CALC -> the next cycle shows busy=0, done=0, result=16'h0000, and no done pulse follows; a new start then completes correctly.
REQ-035 Bench SHALL cover: WIDTH=8, CHUNK=8, add a=8'h80, b=8'h80, ci=0 -> result 8'h00, cout=1, ovf=1; done 2 cycles after the accept edge.
